// File: rtl/mpy_pkg.sv
// Shared definitions for the sequential multiplier and the future divider:
// the FSM state encoding, the default operand width, and the sign-handling
// helpers that both engines use.
package mpy_pkg;

  // Default operand width for the MULT/MULTU path.
  localparam int MPY_DEFAULT_WIDTH = 32;

  // Widest operand the helpers below can handle. Callers zero-extend their
  // operands to this width and slice the result back down.
  localparam int MPY_MAX_W = 64;

  // Engine states: waiting for a request, or iterating.
  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } mpy_state_e;

  // Magnitude of a two's-complement value. The caller supplies the operand's
  // own sign bit because the operand has been zero-extended to MPY_MAX_W;
  // only the caller's low WIDTH bits of the result are meaningful.
  // -2^(WIDTH-1) maps to 2^(WIDTH-1), which still fits unsigned WIDTH bits.
  function automatic logic [MPY_MAX_W-1:0] abs_val(
    input logic [MPY_MAX_W-1:0] v,
    input logic                 is_neg
  );
    logic [MPY_MAX_W-1:0] r;
    if (is_neg) begin
      r = ~v + MPY_MAX_W'(1);
    end else begin
      r = v;
    end
    return r;
  endfunction

  // Two's-complement negation of a double-width product. Negation modulo
  // 2^N is exact in the low N bits, so the caller slices what it needs.
  function automatic logic [2*MPY_MAX_W-1:0] negate2w(
    input logic [2*MPY_MAX_W-1:0] v
  );
    return ~v + (2*MPY_MAX_W)'(1);
  endfunction

endpackage

// File: rtl/mpy_step.sv
// One radix-2 shift-add iteration: conditionally add the multiplicand into
// the upper accumulator half, then shift {carry, acc_hi, multiplier} right.
module mpy_step #(
  parameter int WIDTH = 32
) (
  input  logic             carry_i,
  input  logic [WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0] mplier_i,
  input  logic [WIDTH-1:0] mcand_i,
  output logic             carry_o,
  output logic [WIDTH-1:0] acc_o,
  output logic [WIDTH-1:0] mplier_o
);

  logic [WIDTH:0] sum_s;

  // Add-then-shift for a single multiplier bit.
  always_comb begin
    sum_s = {carry_i, acc_i};
    if (mplier_i[0]) begin
      sum_s = {carry_i, acc_i} + {1'b0, mcand_i};
    end else begin
      sum_s = {carry_i, acc_i};
    end
    // The carry is folded into the accumulator by the shift, so the carry
    // slot always refills with zero.
    carry_o  = 1'b0;
    acc_o    = sum_s[WIDTH:1];
    mplier_o = {sum_s[0], mplier_i[WIDTH-1:1]};
  end

endmodule

// File: rtl/mpy_seq.sv
// Multi-cycle signed/unsigned multiplier for MULT/MULTU. Operand magnitudes
// are multiplied one bit per cycle and the sign is re-applied on the final
// iteration, so Y_hi/Y_lo only ever change to a complete product.
// Supports 4 <= WIDTH <= mpy_pkg::MPY_MAX_W.
module mpy_seq
  import mpy_pkg::*;
#(
  parameter int WIDTH = MPY_DEFAULT_WIDTH,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sgn,
  input  logic [WIDTH-1:0] S,
  input  logic [WIDTH-1:0] T,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Y_hi,
  output logic [WIDTH-1:0] Y_lo
);

  // Counter value seen on the edge that completes the final iteration.
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  mpy_state_e         state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               carry_q;
  logic [WIDTH-1:0]   acc_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [WIDTH-1:0]   mcand_q;
  logic               neg_q;
  logic               busy_q;
  logic               done_q;
  logic [WIDTH-1:0]   y_hi_q;
  logic [WIDTH-1:0]   y_lo_q;

  logic               carry_d;
  logic [WIDTH-1:0]   acc_d;
  logic [WIDTH-1:0]   mplier_d;

  logic [MPY_MAX_W-1:0]   s_abs_s;
  logic [MPY_MAX_W-1:0]   t_abs_s;
  logic [WIDTH-1:0]       s_mag_s;
  logic [WIDTH-1:0]       t_mag_s;
  logic                   neg_in_s;
  logic [2*WIDTH-1:0]     prod_raw_s;
  logic [2*MPY_MAX_W-1:0] prod_neg_s;
  logic [2*WIDTH-1:0]     prod_fix_s;

  mpy_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .carry_i  (carry_q),
    .acc_i    (acc_q),
    .mplier_i (mplier_q),
    .mcand_i  (mcand_q),
    .carry_o  (carry_d),
    .acc_o    (acc_d),
    .mplier_o (mplier_d)
  );

  // Operand magnitudes and result sign, captured when a request is accepted.
  always_comb begin
    s_abs_s  = abs_val(MPY_MAX_W'(S), S[WIDTH-1]);
    t_abs_s  = abs_val(MPY_MAX_W'(T), T[WIDTH-1]);
    neg_in_s = sgn & (S[WIDTH-1] ^ T[WIDTH-1]);
    if (sgn) begin
      s_mag_s = s_abs_s[WIDTH-1:0];
      t_mag_s = t_abs_s[WIDTH-1:0];
    end else begin
      s_mag_s = S;
      t_mag_s = T;
    end
  end

  // Sign fix-up of the product formed by the final iteration.
  always_comb begin
    prod_raw_s = {acc_d, mplier_d};
    prod_neg_s = negate2w((2*MPY_MAX_W)'(prod_raw_s));
    if (neg_q) begin
      prod_fix_s = prod_neg_s[2*WIDTH-1:0];
    end else begin
      prod_fix_s = prod_raw_s;
    end
  end

  // Control FSM, iteration datapath and registered result/handshake outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      acc_q    <= '0;
      mplier_q <= '0;
      mcand_q  <= '0;
      neg_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      y_hi_q   <= '0;
      y_lo_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            mcand_q  <= s_mag_s;
            mplier_q <= t_mag_s;
            acc_q    <= '0;
            carry_q  <= 1'b0;
            neg_q    <= neg_in_s;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= CALC;
          end else begin
            busy_q   <= 1'b0;
            state_q  <= IDLE;
          end
        end
        CALC: begin
          // start is deliberately not looked at here: a request while busy
          // must leave the operation in flight untouched.
          carry_q  <= carry_d;
          acc_q    <= acc_d;
          mplier_q <= mplier_d;
          cnt_q    <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST_ITER) begin
            y_hi_q  <= prod_fix_s[2*WIDTH-1:WIDTH];
            y_lo_q  <= prod_fix_s[WIDTH-1:0];
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            done_q  <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= CALC;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign Y_hi = y_hi_q;
  assign Y_lo = y_lo_q;

endmodule

// File: tb/tb_mpy_seq.sv
// Scoreboard bench for mpy_seq: a 32-bit instance driven with hand-computed
// directed vectors and an 8-bit instance driven with random operands checked
// against a behavioural product. Stimulus pushes expectations; monitors pop
// and compare whenever done is presented.
module tb_mpy_seq;

  localparam int W  = 32;
  localparam int W8 = 8;

  logic          clk   = 1'b0;
  logic          reset = 1'b0;

  logic          start = 1'b0;
  logic          sgn   = 1'b0;
  logic [W-1:0]  s     = '0;
  logic [W-1:0]  t     = '0;
  logic          busy, done;
  logic [W-1:0]  y_hi, y_lo;

  logic          start8 = 1'b0;
  logic          sgn8   = 1'b0;
  logic [W8-1:0] s8     = '0;
  logic [W8-1:0] t8     = '0;
  logic          busy8, done8;
  logic [W8-1:0] y_hi8, y_lo8;

  int checks    = 0;
  int passes    = 0;
  int cyc       = 0;
  int done_seen = 0;

  logic [2*W-1:0]  exp_q[$];
  int              exp_cyc_q[$];
  logic [2*W8-1:0] exp8_q[$];
  int              exp8_cyc_q[$];

  typedef struct {
    logic          sg;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [2*W-1:0] p;
  } vec_t;

  vec_t vecs[7] = '{
    '{1'b0, 32'h0000_0007, 32'h0000_0006, 64'h0000_0000_0000_002A},
    '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001},
    '{1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 64'hFFFF_FFFF_FFFF_FFFF},
    '{1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000},
    '{1'b1, 32'h8000_0000, 32'h0000_0001, 64'hFFFF_FFFF_8000_0000},
    '{1'b1, 32'h7FFF_FFFF, 32'h8000_0000, 64'hC000_0000_8000_0000},
    '{1'b1, 32'hFFFF_FFFD, 32'h0000_0005, 64'hFFFF_FFFF_FFFF_FFF1}
  };

  mpy_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .sgn   (sgn),
    .S     (s),
    .T     (t),
    .busy  (busy),
    .done  (done),
    .Y_hi  (y_hi),
    .Y_lo  (y_lo)
  );

  mpy_seq #(.WIDTH(W8)) dut8 (
    .clk   (clk),
    .reset (reset),
    .start (start8),
    .sgn   (sgn8),
    .S     (s8),
    .T     (t8),
    .busy  (busy8),
    .done  (done8),
    .Y_hi  (y_hi8),
    .Y_lo  (y_lo8)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act === req) begin
      passes++;
    end else begin
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // 32-bit monitor: pop one expectation per done pulse.
  always @(negedge clk) begin
    if (reset && done) begin
      done_seen++;
      check("busy_low_at_done", {127'd0, busy}, 128'd0);
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_done: got done=1 with nothing outstanding, required done=0");
      end else begin
        check("result32", {64'd0, y_hi, y_lo}, {64'd0, exp_q.pop_front()});
        check("latency32", 128'(cyc - exp_cyc_q.pop_front()), 128'(W));
      end
    end
  end

  // 8-bit monitor.
  always @(negedge clk) begin
    if (reset && done8) begin
      if (exp8_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_done8: got done=1 with nothing outstanding, required done=0");
      end else begin
        check("result8", {112'd0, y_hi8, y_lo8}, {112'd0, exp8_q.pop_front()});
        check("latency8", 128'(cyc - exp8_cyc_q.pop_front()), 128'(W8));
      end
    end
  end

  // Call at a negedge; returns just after the accepting edge.
  task automatic issue(input logic sg, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [2*W-1:0] p);
    start = 1'b1;
    sgn   = sg;
    s     = a;
    t     = b;
    @(posedge clk);
    #1;
    exp_q.push_back(p);
    exp_cyc_q.push_back(cyc);
    start = 1'b0;
    sgn   = $urandom_range(0, 1);
    s     = $urandom;
    t     = $urandom;
  endtask

  // Returns at the negedge where done is seen, or flags a timeout.
  task automatic wait_done(input string name);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!done && k < 100);
    if (!done) begin
      checks++;
      $display("FAIL %s_timeout: got no done in %0d cycles, required done", name, k);
    end
  endtask

  task automatic wait_done8();
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!done8 && k < 100);
    if (!done8) begin
      checks++;
      $display("FAIL done8_timeout: got no done in %0d cycles, required done", k);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [W-1:0] last_hi, last_lo;
    int n0;

    // Reset state, both while asserted and just after release.
    repeat (3) @(negedge clk);
    check("rst_outputs", {63'd0, busy, done, y_hi, y_lo}, 128'd0);
    reset = 1'b1;
    @(negedge clk);
    check("idle_outputs", {63'd0, busy, done, y_hi, y_lo}, 128'd0);

    // Directed vectors, one at a time.
    foreach (vecs[i]) begin
      issue(vecs[i].sg, vecs[i].a, vecs[i].b, vecs[i].p);
      wait_done("vec");
      @(negedge clk);
    end

    // Mid-operation start is ignored; start during done is accepted.
    issue(1'b0, 32'd3, 32'd5, 64'd15);
    repeat (9) @(posedge clk);
    #1;
    start = 1'b1; s = 32'd9; t = 32'd9; sgn = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("busy_after_ignored_start", {127'd0, busy}, 128'd1);
    wait_done("b2b_first");
    issue(1'b0, 32'd9, 32'd9, 64'd81);
    wait_done("b2b_second");
    @(negedge clk);

    // Asynchronous reset at cycle 12 of an operation.
    issue(1'b0, 32'd100, 32'd200, 64'd20000);
    repeat (12) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("abort_outputs", {63'd0, busy, done, y_hi, y_lo}, 128'd0);
    exp_q.delete();
    exp_cyc_q.delete();
    @(negedge clk);
    reset = 1'b1;
    n0 = done_seen;
    repeat (40) @(negedge clk);
    check("no_done_after_abort", 128'(done_seen - n0), 128'd0);
    check("idle_after_abort", {63'd0, busy, done, y_hi, y_lo}, 128'd0);

    // Engine still usable after an abort; result is then held.
    issue(1'b1, 32'hFFFF_FFFD, 32'h0000_0005, 64'hFFFF_FFFF_FFFF_FFF1);
    wait_done("post_abort");
    last_hi = 32'hFFFF_FFFF;
    last_lo = 32'hFFFF_FFF1;
    repeat (6) @(negedge clk);
    check("result_held", {64'd0, y_hi, y_lo}, {64'd0, last_hi, last_lo});

    // 8-bit instance, random signed/unsigned operands.
    for (int i = 0; i < 8; i++) begin
      logic [W8-1:0]   a, b;
      logic            sg;
      logic [2*W8-1:0] p;
      a  = W8'($urandom);
      b  = W8'($urandom);
      sg = 1'($urandom_range(0, 1));
      if (i == 0) begin a = 8'h80; b = 8'h80; sg = 1'b1; end
      if (i == 1) begin a = 8'hFF; b = 8'hFF; sg = 1'b0; end
      if (sg) p = $signed(a) * $signed(b);
      else    p = {8'd0, a} * {8'd0, b};
      start8 = 1'b1; sgn8 = sg; s8 = a; t8 = b;
      @(posedge clk);
      #1;
      exp8_q.push_back(p);
      exp8_cyc_q.push_back(cyc);
      start8 = 1'b0; s8 = W8'($urandom); t8 = W8'($urandom);
      wait_done8();
      @(negedge clk);
    end

    check("sb32_drained", 128'(exp_q.size()), 128'd0);
    check("sb8_drained", 128'(exp8_q.size()), 128'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
